// File: rtl/multi_ch_serial_out_if.sv
// multi_ch_serial_out_if: decoder-side load/commit bus plus per-channel serial outputs.
interface multi_ch_serial_out_if #(
    parameter int NUM_CH   = 8,
    parameter int DATA_BIT = 32
);
    // One extra bit so an out-of-range channel select can be expressed and flagged
    localparam int CH_W = $clog2(NUM_CH + 1);
    logic                load, start, stop, mode, commit;
    logic [CH_W-1:0]     ch_sel;
    logic [DATA_BIT-1:0] output_pattern, freq_pattern;
    logic [NUM_CH-1:0]   serial_out, bit_tick, done_tick, busy;
    logic                err_tick;
    modport master (
        output load, ch_sel, output_pattern, freq_pattern, start, stop, mode, commit,
        input  serial_out, bit_tick, done_tick, busy, err_tick
    );
    modport slave (
        input  load, ch_sel, output_pattern, freq_pattern, start, stop, mode, commit,
        output serial_out, bit_tick, done_tick, busy, err_tick
    );
endinterface

// File: rtl/multi_ch_serial_out.sv
// multi_ch_serial_out: NUM_CH serial pattern generators with shadow/active banks and synchronised commit.
module multi_ch_serial_out #(
    parameter int NUM_CH   = 8,
    parameter int DATA_BIT = 32,
    parameter int FAST_DIV = 4,
    parameter int SLOW_DIV = 16
) (
    input logic                   clk,
    input logic                   rst,
    multi_ch_serial_out_if.slave  bus
);
    localparam int CH_W    = $clog2(NUM_CH + 1);
    localparam int IW      = $clog2(DATA_BIT);
    localparam int MAX_DIV = FAST_DIV > SLOW_DIV ? FAST_DIV : SLOW_DIV;
    localparam int CW      = $clog2(MAX_DIV + 1);
    localparam logic [CW-1:0] FAST_LAST = CW'(FAST_DIV - 1);
    localparam logic [CW-1:0] SLOW_LAST = CW'(SLOW_DIV - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BIT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic ld_ok;
    assign ld_ok = bus.load && bus.ch_sel < CH_W'(NUM_CH);

    always_ff @(posedge clk) begin
        if (rst)
            bus.err_tick <= 1'b0;
        else
            bus.err_tick <= bus.load && !ld_ok;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t              state, state_nxt;
        logic [DATA_BIT-1:0] sh_out, sh_freq, act_out, act_freq;
        logic [DATA_BIT-1:0] e_out, e_freq, n_out, n_freq;
        logic                sh_start, sh_stop, sh_mode, act_mode, pending;
        logic                hit, upd, e_start, e_stop, e_mode, n_mode;
        logic [CW-1:0]       cnt, cnt_nxt;
        logic [IW-1:0]       idx, idx_nxt;
        logic                cur_bit, cur_fast, bit_nxt, fast_nxt, last, fin;

        // A load landing in the commit cycle bypasses the shadow bank
        assign hit     = ld_ok && bus.ch_sel == CH_W'(c);
        assign upd     = bus.commit && (pending || hit);
        assign e_out   = hit ? bus.output_pattern : sh_out;
        assign e_freq  = hit ? bus.freq_pattern : sh_freq;
        assign e_start = hit ? bus.start : sh_start;
        assign e_stop  = hit ? bus.stop : sh_stop;
        assign e_mode  = hit ? bus.mode : sh_mode;
        assign n_out   = upd ? e_out : act_out;
        assign n_freq  = upd ? e_freq : act_freq;
        assign n_mode  = upd ? e_mode : act_mode;
        assign last    = state == RUN && cnt == (cur_fast ? FAST_LAST : SLOW_LAST);
        assign fin     = last && idx == LAST_BIT;

        // The current bit and its rate are latched, so a data-only commit waits for the next boundary
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            idx_nxt   = idx;
            bit_nxt   = cur_bit;
            fast_nxt  = cur_fast;
            if (state == RUN) begin
                cnt_nxt = last ? '0 : cnt + CW'(1);
                if (last) begin
                    idx_nxt  = fin ? '0 : idx + IW'(1);
                    bit_nxt  = n_out[idx_nxt];
                    fast_nxt = n_freq[idx_nxt];
                    if (fin && !n_mode)
                        state_nxt = IDLE;
                end
            end
            if (upd && e_stop)
                state_nxt = IDLE;
            else if (upd && e_start) begin
                state_nxt = RUN;
                cnt_nxt   = '0;
                idx_nxt   = '0;
                bit_nxt   = e_out[0];
                fast_nxt  = e_freq[0];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= IDLE;
                cnt      <= '0;
                idx      <= '0;
                cur_bit  <= 1'b0;
                cur_fast <= 1'b0;
                sh_out   <= '0;
                sh_freq  <= '0;
                sh_start <= 1'b0;
                sh_stop  <= 1'b0;
                sh_mode  <= 1'b0;
                act_out  <= '0;
                act_freq <= '0;
                act_mode <= 1'b0;
                pending  <= 1'b0;
            end else begin
                state    <= state_nxt;
                cnt      <= cnt_nxt;
                idx      <= idx_nxt;
                cur_bit  <= bit_nxt;
                cur_fast <= fast_nxt;
                act_out  <= n_out;
                act_freq <= n_freq;
                act_mode <= n_mode;
                pending  <= !upd && (pending || hit);
                if (hit) begin
                    sh_out   <= bus.output_pattern;
                    sh_freq  <= bus.freq_pattern;
                    sh_start <= bus.start;
                    sh_stop  <= bus.stop;
                    sh_mode  <= bus.mode;
                end
            end
        end

        assign bus.serial_out[c] = state == RUN && cur_bit;
        assign bus.bit_tick[c]   = last;
        assign bus.done_tick[c]  = fin;
        assign bus.busy[c]       = state == RUN;
    end
endmodule

// File: tb/tb_multi_ch_serial_out.sv
// tb_multi_ch_serial_out: table-driven one-shot runs plus directed commit/repeat/error/reset sequences.
module tb_multi_ch_serial_out;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_ch_serial_out_if #(.NUM_CH(8), .DATA_BIT(32)) bus();
    multi_ch_serial_out #(.NUM_CH(8), .DATA_BIT(32), .FAST_DIV(4), .SLOW_DIV(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          ch;
        logic [31:0] out;
        logic [31:0] freq;
        int          done_at;
    } vec_t;

    vec_t        vecs[4];
    int          checks, errors;
    int          bad, done_at, ticks, gap, dn, d1, d2;
    logic [3:0]  m;
    logic [31:0] exp_w, got_w;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic op(input logic ld, input int ch, input logic [31:0] o, input logic [31:0] f,
                      input logic st, input logic sp, input logic md, input logic cm);
        bus.load           = ld;
        bus.ch_sel         = ch[3:0];
        bus.output_pattern = o;
        bus.freq_pattern   = f;
        bus.start          = st;
        bus.stop           = sp;
        bus.mode           = md;
        bus.commit         = cm;
        @(posedge clk);
        #1;
        bus.load   = 1'b0;
        bus.commit = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference timing for a one-shot pass; k=1 is the first cycle after the commit edge.
    // Returns {busy, serial, bit_tick, done_tick}.
    function automatic logic [3:0] model(input logic [31:0] o, input logic [31:0] f, input int k);
        int t, d;
        t = 0;
        for (int i = 0; i < 32; i++) begin
            d = f[i] ? 4 : 16;
            if (k - 1 < t + d)
                return {1'b1, o[i], k - 1 == t + d - 1, (k - 1 == t + d - 1) && i == 31};
            t += d;
        end
        return 4'b0;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{0, 32'hA5A5_0F0F, ONES,         128};
        vecs[1] = '{0, ONES,          32'h0000_0001, 500};
        vecs[2] = '{6, 32'h8000_0001, 32'h5555_5555, 320};
        vecs[3] = '{7, 32'h1234_5678, 32'h0000_0000, 512};
        bus.load = 0; bus.ch_sel = 0; bus.output_pattern = 0; bus.freq_pattern = 0;
        bus.start = 0; bus.stop = 0; bus.mode = 0; bus.commit = 0;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_serial", bus.serial_out, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_bit_tick", bus.bit_tick, 0);
        chk("reset_done_tick", bus.done_tick, 0);
        chk("reset_err_tick", bus.err_tick, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            op(1, vecs[v].ch, vecs[v].out, vecs[v].freq, 1, 0, 0, 0);
            op(0, 0, 0, 0, 0, 0, 0, 1);
            bad = 0; done_at = -1; ticks = 0;
            for (int k = 1; k <= vecs[v].done_at + 3; k++) begin
                @(negedge clk);
                m = model(vecs[v].out, vecs[v].freq, k);
                exp_w = {8'(m[3]) << vecs[v].ch, 8'(m[2]) << vecs[v].ch,
                         8'(m[1]) << vecs[v].ch, 8'(m[0]) << vecs[v].ch};
                got_w = {bus.busy, bus.serial_out, bus.bit_tick, bus.done_tick};
                if (got_w !== exp_w) begin
                    if (bad == 0)
                        $display("FAIL wave v%0d k=%0d: got %h expected %h", v, k, got_w, exp_w);
                    bad++;
                end
                if (bus.done_tick[vecs[v].ch] && done_at < 0) done_at = k;
                if (bus.bit_tick[vecs[v].ch]) ticks++;
                @(posedge clk);
                #1;
            end
            chk($sformatf("done_cycle_v%0d", v), done_at, vecs[v].done_at);
            chk($sformatf("wave_bad_cycles_v%0d", v), bad, 0);
            chk($sformatf("bit_ticks_v%0d", v), ticks, 32);
        end

        // Synchronised start of ch1 (pending) and ch5 (bypass load in commit cycle)
        op(1, 1, ONES, ONES, 1, 0, 1, 0);
        op(1, 5, ONES, ONES, 1, 0, 1, 1);
        @(negedge clk);
        chk("sync_busy", bus.busy, 8'h22);
        chk("sync_serial", bus.serial_out, 8'h22);
        @(posedge clk);
        #1;
        op(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(5);
        @(negedge clk);
        chk("noop_commit_busy", bus.busy, 8'h22);
        @(posedge clk);
        #1;
        op(1, 1, 0, 0, 0, 1, 0, 0);
        op(1, 5, 0, 0, 0, 1, 0, 1);
        @(negedge clk);
        chk("sync_stop_busy", bus.busy, 8'h00);
        @(posedge clk);
        #1;

        // Repeat mode: done every 128 clocks with no gap, then stop mid-pass
        op(1, 2, ONES, ONES, 1, 0, 1, 1);
        gap = 0; dn = 0; d1 = -1; d2 = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (!bus.serial_out[2]) gap++;
            if (bus.done_tick[2]) begin
                dn++;
                if (dn == 1) d1 = k;
                if (dn == 2) d2 = k;
            end
            @(posedge clk);
            #1;
        end
        chk("repeat_first_done", d1, 128);
        chk("repeat_second_done", d2, 256);
        chk("repeat_done_count", dn, 2);
        chk("repeat_gap_cycles", gap, 0);
        op(1, 2, 0, 0, 0, 1, 0, 0);
        op(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("stop_serial_busy", {bus.serial_out[2], bus.busy[2]}, 2'b00);
        dn = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (bus.done_tick[2]) dn++;
        end
        chk("stop_no_done", dn, 0);
        @(posedge clk);
        #1;

        // Out-of-range select, then double load before commit
        op(1, 9, 32'hDEAD_BEEF, ONES, 1, 0, 1, 0);
        @(negedge clk);
        chk("err_tick_high", bus.err_tick, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("err_tick_pulse", bus.err_tick, 0);
        @(posedge clk);
        #1;
        op(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("err_no_channel", bus.busy, 8'h00);
        @(posedge clk);
        #1;
        op(1, 2, 0, ONES, 1, 0, 0, 0);
        op(1, 2, ONES, ONES, 1, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("double_load_last_wins", {bus.busy[2], bus.serial_out[2], bus.err_tick}, 3'b110);
        @(posedge clk);
        #1;
        cyc(130);

        // Restart, stop-over-start priority, then reset mid-run
        op(1, 0, ONES, ONES, 1, 0, 1, 0);
        op(1, 3, ONES, ONES, 1, 0, 1, 0);
        op(1, 4, ONES, ONES, 1, 0, 1, 1);
        cyc(10);
        @(negedge clk);
        chk("three_busy", bus.busy, 8'h19);
        @(posedge clk);
        #1;
        op(1, 0, 0, 0, 1, 0, 1, 1);
        @(negedge clk);
        chk("restart_ch0", {bus.busy[0], bus.serial_out[0]}, 2'b10);
        @(posedge clk);
        #1;
        op(1, 4, ONES, ONES, 1, 1, 1, 1);
        @(negedge clk);
        chk("stop_priority_busy", bus.busy, 8'h09);
        @(posedge clk);
        #1;
        op(1, 6, ONES, ONES, 1, 0, 1, 0);
        cyc(3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrun_reset_outputs",
            {bus.busy, bus.serial_out, bus.bit_tick, bus.done_tick, 7'b0, bus.err_tick}, 0);
        @(posedge clk);
        #1;
        op(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("post_reset_commit_noop", bus.busy, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
